// File: rtl/life_gen_engine.sv
// life_gen_engine: streaming Game of Life next-generation engine with birth/survive masks.
// Define TOROIDAL_EN for wrap-around edges (row 0 output deferred to the end of the frame).
module life_gen_engine #(
    parameter int GRID_W = 1280,
    parameter int GRID_H = 720,
    parameter int LANES  = 64,
    parameter int ROW_AW = 10
) (
    input  logic              out_stream_aclk,
    input  logic              periph_resetn,
    input  logic              start,
    input  logic              pause,
    input  logic [8:0]        birth_mask,
    input  logic [8:0]        survive_mask,
    input  logic [GRID_W-1:0] in_row_data,
    input  logic              in_row_valid,
    output logic              in_row_ready,
    output logic [GRID_W-1:0] out_row_data,
    output logic [ROW_AW-1:0] out_row_addr,
    output logic              out_row_valid,
    input  logic              out_row_ready,
    output logic              out_row_last,
    output logic              busy,
    output logic [15:0]       gen_count
);
    localparam int NC = GRID_W / LANES;
    localparam int CW = $clog2(NC + 1);
    localparam int EW = GRID_W + 2;
    localparam int BW = $clog2(EW);
    localparam int RW = ROW_AW + 1;
    localparam logic [CW-1:0] LAST_CHUNK = CW'(NC - 1);
    localparam logic [CW-1:0] DONE_CHUNK = CW'(NC);
    localparam logic [RW-1:0] ROWS_ALL   = RW'(GRID_H);
`ifdef TOROIDAL_EN
    localparam logic [RW-1:0] FIRST_OUT  = RW'(2);
`else
    localparam logic [RW-1:0] FIRST_OUT  = RW'(1);
`endif

    typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, OUTPUT, FLUSH} state_t;

    // Extend a row by one cell on each side: ext[k] holds column k-1.
    function automatic logic [EW-1:0] pad_row(input logic [GRID_W-1:0] r);
`ifdef TOROIDAL_EN
        pad_row = {r[0], r, r[GRID_W-1]};
`else
        pad_row = {1'b0, r, 1'b0};
`endif
    endfunction

    function automatic logic [LANES-1:0] next_cells(
        input logic [LANES+1:0] t,
        input logic [LANES+1:0] m,
        input logic [LANES+1:0] b,
        input logic [8:0]       bm,
        input logic [8:0]       sm
    );
        logic [3:0] n;
        next_cells = '0;
        for (int j = 0; j < LANES; j++) begin
            n = 4'(t[j]) + 4'(t[j+1]) + 4'(t[j+2]) + 4'(m[j]) + 4'(m[j+2])
              + 4'(b[j]) + 4'(b[j+1]) + 4'(b[j+2]);
            next_cells[j] = m[j+1] ? sm[n] : bm[n];
        end
    endfunction

    state_t            state, state_nxt;
    logic [GRID_W-1:0] row_top, row_mid, row_bot;
    logic [GRID_W-1:0] pad_bot;
    logic [RW-1:0]     rows_in;
    logic [8:0]        birth_q, survive_q;
    logic [CW-1:0]     chunk_p0;
    logic [BW-1:0]     base_p0;
    logic [LANES-1:0]  cells_p0;
    logic [LANES-1:0]  res_p1;
    logic [CW-1:0]     idx_p1;
    logic              vld_p1;
    logic              last_q;
    logic              all_rows_in;
    logic [EW-1:0]     ext_top, ext_mid, ext_bot;
`ifdef TOROIDAL_EN
    logic [GRID_W-1:0] save0, save1;
    logic              flushed;

    assign pad_bot = flushed ? save1 : save0;
`else
    assign pad_bot = '0;
`endif

    assign ext_top     = pad_row(row_top);
    assign ext_mid     = pad_row(row_mid);
    assign ext_bot     = pad_row(row_bot);
    assign base_p0     = BW'(chunk_p0) * BW'(LANES);
    assign cells_p0    = next_cells(ext_top[base_p0 +: LANES+2], ext_mid[base_p0 +: LANES+2],
                                    ext_bot[base_p0 +: LANES+2], birth_q, survive_q);
    assign all_rows_in = (rows_in == ROWS_ALL);

    assign in_row_ready  = (state == LOAD);
    assign out_row_valid = (state == OUTPUT);
    assign out_row_last  = out_row_valid && last_q;
    assign busy          = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    if (in_row_valid && rows_in >= FIRST_OUT) state_nxt = COMPUTE;
            COMPUTE,
            FLUSH:   if (!pause && vld_p1 && idx_p1 == LAST_CHUNK) state_nxt = OUTPUT;
            OUTPUT:  if (out_row_ready) begin
                         if (last_q)            state_nxt = IDLE;
                         else if (!all_rows_in) state_nxt = LOAD;
                         else                   state_nxt = FLUSH;
                     end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) state <= IDLE;
        else                state <= state_nxt;
    end

    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            row_top      <= '0;
            row_mid      <= '0;
            row_bot      <= '0;
            rows_in      <= '0;
            birth_q      <= 9'b000001000;
            survive_q    <= 9'b000001100;
            chunk_p0     <= '0;
            res_p1       <= '0;
            idx_p1       <= '0;
            vld_p1       <= 1'b0;
            last_q       <= 1'b0;
            out_row_data <= '0;
            out_row_addr <= '0;
            gen_count    <= '0;
`ifdef TOROIDAL_EN
            save0        <= '0;
            save1        <= '0;
            flushed      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    birth_q   <= birth_mask;
                    survive_q <= survive_mask;
                    rows_in   <= '0;
                    row_top   <= '0;
                    row_mid   <= '0;
                    row_bot   <= '0;
`ifdef TOROIDAL_EN
                    flushed   <= 1'b0;
`endif
                end
                LOAD: if (in_row_valid) begin
                    row_top <= row_mid;
                    row_mid <= row_bot;
                    row_bot <= in_row_data;
                    rows_in <= rows_in + RW'(1);
`ifdef TOROIDAL_EN
                    if (rows_in == RW'(0)) save0 <= in_row_data;
                    if (rows_in == RW'(1)) save1 <= in_row_data;
`endif
                    if (rows_in >= FIRST_OUT) begin
                        chunk_p0     <= '0;
                        out_row_addr <= ROW_AW'(rows_in - RW'(1));
                        last_q       <= 1'b0;
                    end
                end
                COMPUTE, FLUSH: if (!pause) begin
                    // p0 -> p1: evaluate one chunk of LANES cells
                    vld_p1 <= (chunk_p0 != DONE_CHUNK);
                    if (chunk_p0 != DONE_CHUNK) begin
                        res_p1   <= cells_p0;
                        idx_p1   <= chunk_p0;
                        chunk_p0 <= chunk_p0 + CW'(1);
                    end
                    // p1 -> output row buffer
                    if (vld_p1) begin
                        for (int c = 0; c < NC; c++)
                            if (idx_p1 == CW'(c)) out_row_data[c*LANES +: LANES] <= res_p1;
                    end
                end
                OUTPUT: if (out_row_ready) begin
                    if (last_q) begin
                        gen_count <= gen_count + 16'd1;
                    end else if (all_rows_in) begin
                        row_top  <= row_mid;
                        row_mid  <= row_bot;
                        row_bot  <= pad_bot;
                        chunk_p0 <= '0;
`ifdef TOROIDAL_EN
                        flushed      <= 1'b1;
                        out_row_addr <= flushed ? '0 : ROW_AW'(GRID_H - 1);
                        last_q       <= flushed;
`else
                        out_row_addr <= ROW_AW'(GRID_H - 1);
                        last_q       <= 1'b1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
